// File: rtl/mem_arb_pkg.sv
// Shared types and constants for the I/D memory port arbiter.
// Timer width is derived from the response timeout.
package mem_arb_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_WAIT = 2'd1,
    ST_RESP = 2'd2
  } state_t;

  localparam logic OWN_I = 1'b0;
  localparam logic OWN_D = 1'b1;

  localparam int DEF_TIMEOUT = 16;

  function automatic int tmr_w(input int t);
    return (t < 3) ? 1 : $clog2(t);
  endfunction

endpackage

// File: rtl/arb_rr2.sv
// Two-way round-robin picker: under contention the side
// that did not win last time is selected.
module arb_rr2
  import mem_arb_pkg::*;
(
  input  logic req_i,
  input  logic req_d,
  input  logic last_grant,
  output logic gnt_valid,
  output logic gnt_sel
);

  logic w_both;

  assign w_both    = req_i & req_d;
  assign gnt_valid = req_i | req_d;
  assign gnt_sel   = w_both
                   ? ((last_grant == OWN_D) ? OWN_I : OWN_D)
                   : (req_d ? OWN_D : OWN_I);

endmodule

// File: rtl/mem_port_arbiter.sv
// Shares one variable-latency memory port between instruction
// fetch and data access, with round-robin and response timeout.
module mem_port_arbiter
  import mem_arb_pkg::*;
#(
  parameter int AW      = 32,
  parameter int DW      = 32,
  parameter int TIMEOUT = DEF_TIMEOUT
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          i_req,
  input  logic [AW-1:0] i_addr,
  output logic          i_ready,
  output logic [DW-1:0] i_rdata,
  output logic          i_err,
  input  logic          d_req,
  input  logic          d_we,
  input  logic [AW-1:0] d_addr,
  input  logic [DW-1:0] d_wdata,
  output logic          d_ready,
  output logic [DW-1:0] d_rdata,
  output logic          d_err,
  output logic          m_req,
  output logic          m_we,
  output logic [AW-1:0] m_addr,
  output logic [DW-1:0] m_wdata,
  input  logic          m_ack,
  input  logic [DW-1:0] m_rdata,
  output logic          busy,
  output logic          owner
);

  localparam int TW = tmr_w(TIMEOUT);
  localparam logic [TW-1:0] TMAX = TW'(TIMEOUT - 1);

  state_t        r_state;
  logic          r_last;
  logic [TW-1:0] r_timer;

  logic w_gnt_valid;
  logic w_gnt_sel;
  logic w_done;

  arb_rr2 u_rr (
    .req_i      (i_req),
    .req_d      (d_req),
    .last_grant (r_last),
    .gnt_valid  (w_gnt_valid),
    .gnt_sel    (w_gnt_sel)
  );

  // An ack in the last WAIT cycle takes precedence over the timeout
  assign w_done = m_ack || (r_timer == TMAX);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state <= ST_IDLE;
      r_last  <= OWN_D;
      r_timer <= '0;
      i_ready <= 1'b0;
      i_rdata <= '0;
      i_err   <= 1'b0;
      d_ready <= 1'b0;
      d_rdata <= '0;
      d_err   <= 1'b0;
      m_req   <= 1'b0;
      m_we    <= 1'b0;
      m_addr  <= '0;
      m_wdata <= '0;
      busy    <= 1'b0;
      owner   <= OWN_I;
    end else begin
      i_ready <= 1'b0;
      d_ready <= 1'b0;
      unique case (r_state)
        ST_IDLE: begin
          if (w_gnt_valid) begin
            m_req   <= 1'b1;
            m_we    <= (w_gnt_sel == OWN_D) & d_we;
            m_addr  <= (w_gnt_sel == OWN_D) ? d_addr : i_addr;
            m_wdata <= (w_gnt_sel == OWN_D) ? d_wdata : '0;
            owner   <= w_gnt_sel;
            r_last  <= w_gnt_sel;
            r_timer <= '0;
            r_state <= ST_WAIT;
            busy    <= 1'b1;
          end
        end
        ST_WAIT: begin
          if (w_done) begin
            m_req   <= 1'b0;
            r_state <= ST_RESP;
            if (owner == OWN_D) begin
              d_ready <= 1'b1;
              d_rdata <= (m_ack && !m_we) ? m_rdata : '0;
              d_err   <= !m_ack;
            end else begin
              i_ready <= 1'b1;
              i_rdata <= m_ack ? m_rdata : '0;
              i_err   <= !m_ack;
            end
          end else begin
            r_timer <= r_timer + 1'b1;
          end
        end
        ST_RESP: begin
          r_state <= ST_IDLE;
          busy    <= 1'b0;
        end
        default: begin
          r_state <= ST_IDLE;
          busy    <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Scoreboard bench for mem_port_arbiter with a behavioural
// memory whose latency and liveness each scenario configures.
module tb_mem_port_arbiter;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        i_req = 1'b0;
  logic [31:0] i_addr = '0;
  logic        i_ready;
  logic [31:0] i_rdata;
  logic        i_err;
  logic        d_req = 1'b0;
  logic        d_we = 1'b0;
  logic [31:0] d_addr = '0;
  logic [31:0] d_wdata = '0;
  logic        d_ready;
  logic [31:0] d_rdata;
  logic        d_err;
  logic        m_req;
  logic        m_we;
  logic [31:0] m_addr;
  logic [31:0] m_wdata;
  logic        m_ack;
  logic [31:0] m_rdata;
  logic        busy;
  logic        owner;

  int checks = 0;
  int failures = 0;

  logic [32:0] sb_i[$];
  logic [32:0] sb_d[$];

  int          mem_lat = 0;
  bit          mem_dead = 1'b0;
  bit          mem_fix_en = 1'b0;
  logic [31:0] mem_fix = '0;
  int          mcnt = 0;
  logic        mdl_ack = 1'b0;
  logic [31:0] mdl_rdata = '0;
  logic        man_ack = 1'b0;
  logic [31:0] man_rdata = '0;

  assign m_ack   = mdl_ack | man_ack;
  assign m_rdata = man_ack ? man_rdata : mdl_rdata;

  always #5 clk = ~clk;

  mem_port_arbiter dut (
    .clk     (clk),
    .reset   (reset),
    .i_req   (i_req),
    .i_addr  (i_addr),
    .i_ready (i_ready),
    .i_rdata (i_rdata),
    .i_err   (i_err),
    .d_req   (d_req),
    .d_we    (d_we),
    .d_addr  (d_addr),
    .d_wdata (d_wdata),
    .d_ready (d_ready),
    .d_rdata (d_rdata),
    .d_err   (d_err),
    .m_req   (m_req),
    .m_we    (m_we),
    .m_addr  (m_addr),
    .m_wdata (m_wdata),
    .m_ack   (m_ack),
    .m_rdata (m_rdata),
    .busy    (busy),
    .owner   (owner)
  );

  function automatic logic [31:0] mem_val(input logic [31:0] a);
    return a ^ 32'hDEAD_BEEF;
  endfunction

  // memory: acks when m_req has been seen high mem_lat+1 times
  initial forever begin
    @(negedge clk);
    mdl_ack = 1'b0;
    if (m_req) begin
      if (!mem_dead && mcnt == mem_lat) begin
        mdl_ack   = 1'b1;
        mdl_rdata = mem_fix_en ? mem_fix : mem_val(m_addr);
      end
      mcnt++;
    end else begin
      mcnt = 0;
    end
  end

  // requesters drop req on the edge after their ready pulse
  initial forever begin
    @(negedge clk);
    if (i_ready) i_req = 1'b0;
    if (d_ready) d_req = 1'b0;
  end

  initial forever begin
    @(negedge clk);
    if (i_ready && d_ready) begin
      checks++;
      failures++;
      $display("FAIL both_ready got=11 want=one");
    end
    if (i_ready) begin
      logic [33:0] got;
      logic [33:0] want;
      checks++;
      got = {i_err, i_rdata, owner};
      if (sb_i.size() == 0) begin
        failures++;
        $display("FAIL spurious_i_ready got=%h want=none", got);
      end else begin
        want = {sb_i.pop_front(), 1'b0};
        if (got !== want) begin
          failures++;
          $display("FAIL i_resp got=%h want=%h", got, want);
        end
      end
    end
    if (d_ready) begin
      logic [33:0] got;
      logic [33:0] want;
      checks++;
      got = {d_err, d_rdata, owner};
      if (sb_d.size() == 0) begin
        failures++;
        $display("FAIL spurious_d_ready got=%h want=none", got);
      end else begin
        want = {sb_d.pop_front(), 1'b1};
        if (got !== want) begin
          failures++;
          $display("FAIL d_resp got=%h want=%h", got, want);
        end
      end
    end
  end

  task automatic issue_i(input logic [31:0] a, input logic [32:0] e);
    i_addr = a;
    i_req  = 1'b1;
    sb_i.push_back(e);
  endtask

  task automatic issue_d(input logic we, input logic [31:0] a,
                         input logic [31:0] wd, input logic [32:0] e);
    d_we    = we;
    d_addr  = a;
    d_wdata = wd;
    d_req   = 1'b1;
    sb_d.push_back(e);
  endtask

  task automatic wait_idle(output bit ok);
    ok = 1'b0;
    for (int n = 0; n < 80; n++) begin
      @(negedge clk);
      if (sb_i.size() == 0 && sb_d.size() == 0 &&
          !busy && !i_req && !d_req) begin
        ok = 1'b1;
        return;
      end
    end
  endtask

  task automatic do_reset();
    @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
  endtask

  task automatic test_reset();
    @(negedge clk);
    checks++;
    if ({m_req, m_we, m_addr, m_wdata, i_ready, i_rdata, i_err,
         d_ready, d_rdata, d_err, busy, owner} !== '0) begin
      failures++;
      $display("FAIL reset_outputs got=%b/%h/%h/%b/%b/%h want=0",
               m_req, m_addr, m_wdata, i_ready, busy, owner);
    end
    reset = 1'b0;
  endtask

  task automatic test_zero_wait();
    bit ok;
    mem_lat = 0;
    mem_fix_en = 1'b1;
    mem_fix = 32'h8C01_0004;
    @(negedge clk);
    issue_i(32'h40, {1'b0, 32'h8C01_0004});
    @(negedge clk);
    checks++;
    if ({m_req, m_we, m_addr, busy} !== {1'b1, 1'b0, 32'h40, 1'b1}) begin
      failures++;
      $display("FAIL zw_issue got=%b/%b/%h/%b want=1/0/00000040/1",
               m_req, m_we, m_addr, busy);
    end
    @(negedge clk);
    checks++;
    if ({m_req, i_ready, d_ready, owner} !== 4'b0100) begin
      failures++;
      $display("FAIL zw_ready got=%b%b%b%b want=0100",
               m_req, i_ready, d_ready, owner);
    end
    wait_idle(ok);
    checks++;
    if (!ok) begin
      failures++;
      $display("FAIL zw_drain got=stuck want=idle");
    end
    mem_fix_en = 1'b0;
  endtask

  task automatic test_contention();
    bit ok;
    bit seen_i = 1'b0;
    bit seen_d = 1'b0;
    do_reset();
    mem_lat = 3;
    @(negedge clk);
    issue_i(32'h80, {1'b0, mem_val(32'h80)});
    issue_d(1'b1, 32'h100, 32'hA5A5_A5A5, {1'b0, 32'h0});
    for (int n = 0; n < 40 && !(seen_i && seen_d); n++) begin
      @(negedge clk);
      if (m_req && owner == 1'b0 && !seen_i) begin
        seen_i = 1'b1;
        checks++;
        if (seen_d || {m_we, m_addr, m_wdata} !== {1'b0, 32'h80, 32'h0}) begin
          failures++;
          $display("FAIL cont_i_grant got=%b/%b/%h/%h want=first/0/80/0",
                   seen_d, m_we, m_addr, m_wdata);
        end
      end
      if (m_req && owner == 1'b1 && !seen_d) begin
        seen_d = 1'b1;
        checks++;
        if ({m_we, m_addr, m_wdata} !== {1'b1, 32'h100, 32'hA5A5_A5A5}) begin
          failures++;
          $display("FAIL cont_d_grant got=%b/%h/%h want=1/100/a5a5a5a5",
                   m_we, m_addr, m_wdata);
        end
      end
    end
    checks++;
    if (!(seen_i && seen_d)) begin
      failures++;
      $display("FAIL cont_grants got=%b%b want=11", seen_i, seen_d);
    end
    wait_idle(ok);
    d_we = 1'b0;
    checks++;
    if (!ok) begin
      failures++;
      $display("FAIL cont_drain got=stuck want=idle");
    end
  endtask

  task automatic test_sustained();
    bit   ok;
    int   ni = 0;
    int   nd = 0;
    int   ng = 0;
    logic prev = 1'b0;
    logic [3:0] seq = '0;
    do_reset();
    mem_lat = 1;
    for (int n = 0; n < 200 && ng < 4; n++) begin
      @(negedge clk);
      if (m_req && !prev) begin
        seq[ng] = owner;
        ng++;
      end
      prev = m_req;
      if (!busy && !i_req && ni < 2) begin
        issue_i(32'h1000 + 32'(ni * 4), {1'b0, mem_val(32'h1000 + 32'(ni * 4))});
        ni++;
      end
      if (!busy && !d_req && nd < 2) begin
        issue_d(1'b0, 32'h2000 + 32'(nd * 4), 32'h0,
                {1'b0, mem_val(32'h2000 + 32'(nd * 4))});
        nd++;
      end
    end
    checks++;
    if (ng != 4 || seq !== 4'b1010) begin
      failures++;
      $display("FAIL rr_sequence got=%0d/%b want=4/1010 (bit0 first)", ng, seq);
    end
    wait_idle(ok);
    checks++;
    if (!ok) begin
      failures++;
      $display("FAIL rr_drain got=stuck want=idle");
    end
  endtask

  task automatic test_timeout();
    int hi = 0;
    bit got_rdy = 1'b0;
    mem_dead = 1'b1;
    @(negedge clk);
    issue_d(1'b0, 32'h200, 32'h0, {1'b1, 32'h0});
    for (int n = 0; n < 40 && !got_rdy; n++) begin
      @(negedge clk);
      if (m_req) hi++;
      if (d_ready) got_rdy = 1'b1;
    end
    checks++;
    if (!got_rdy || hi != 16) begin
      failures++;
      $display("FAIL timeout_len got=%0d/%b want=16/1", hi, got_rdy);
    end
    @(negedge clk);
    checks++;
    if (busy !== 1'b0) begin
      failures++;
      $display("FAIL timeout_busy got=%b want=0", busy);
    end
    mem_dead = 1'b0;
  endtask

  task automatic test_ack_expiry();
    bit ok;
    mem_lat = 15;
    mem_fix_en = 1'b1;
    mem_fix = 32'h1234_5678;
    @(negedge clk);
    issue_d(1'b0, 32'h300, 32'h0, {1'b0, 32'h1234_5678});
    wait_idle(ok);
    checks++;
    if (!ok) begin
      failures++;
      $display("FAIL expiry_drain got=stuck want=idle");
    end
    mem_fix_en = 1'b0;
  endtask

  task automatic test_reset_mid_wait();
    bit ok;
    bit stray = 1'b0;
    bit seen = 1'b0;
    mem_dead = 1'b1;
    @(negedge clk);
    i_addr = 32'h400;
    i_req = 1'b1;
    repeat (3) @(negedge clk);
    #2 reset = 1'b1;
    #1;
    checks++;
    if ({m_req, busy} !== 2'b00) begin
      failures++;
      $display("FAIL async_reset got=%b%b want=00", m_req, busy);
    end
    i_req = 1'b0;
    @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
    @(negedge clk);
    man_rdata = 32'hBAD0_BAD0;
    man_ack = 1'b1;
    @(negedge clk);
    man_ack = 1'b0;
    if (i_ready || d_ready) stray = 1'b1;
    repeat (3) begin
      @(negedge clk);
      if (i_ready || d_ready) stray = 1'b1;
    end
    checks++;
    if (stray || busy) begin
      failures++;
      $display("FAIL late_ack got=%b/%b want=0/0", stray, busy);
    end
    mem_dead = 1'b0;
    mem_lat = 0;
    issue_i(32'h500, {1'b0, mem_val(32'h500)});
    issue_d(1'b0, 32'h600, 32'h0, {1'b0, mem_val(32'h600)});
    for (int n = 0; n < 10 && !seen; n++) begin
      @(negedge clk);
      if (m_req) begin
        seen = 1'b1;
        checks++;
        if (owner !== 1'b0 || m_addr !== 32'h500) begin
          failures++;
          $display("FAIL post_reset_prio got=%b/%h want=0/00000500",
                   owner, m_addr);
        end
      end
    end
    checks++;
    if (!seen) begin
      failures++;
      $display("FAIL post_reset_grant got=none want=grant");
    end
    wait_idle(ok);
    checks++;
    if (!ok) begin
      failures++;
      $display("FAIL post_reset_drain got=stuck want=idle");
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog got=timeout want=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset();
    test_zero_wait();
    test_contention();
    test_sustained();
    test_timeout();
    test_ack_expiry();
    test_reset_mid_wait();
    repeat (2) @(negedge clk);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
